// File: rtl/win_out_at_pkg.sv
// Shared definitions for the Winograd F(2,3) output-transform stage.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package win_out_at_pkg;

  // end_signal encodings: Finish marks the cycle after a result is consumed
  localparam logic Finish   = 1'b1;
  localparam logic UnFinish = 1'b0;

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_STG1 = 3'd1;
  localparam state_t ST_STG2 = 3'd2;
  localparam state_t ST_ACC  = 3'd3;
  localparam state_t ST_OUT  = 3'd4;

  // A-matrix row combinations over operands {a,b,c,d} (bit 3 = a, bit 0 = d).
  // USE selects which operands take part, NEG selects which are subtracted.
  // s1 = a + b + c
  localparam logic [3:0] A_S1_USE = 4'b1110;
  localparam logic [3:0] A_S1_NEG = 4'b0000;
  // s2 = b - c - d
  localparam logic [3:0] A_S2_USE = 4'b0111;
  localparam logic [3:0] A_S2_NEG = 4'b0011;

endpackage

// File: rtl/win_out_at_if.sv
// Tile-in / result-out bus of the Winograd output-transform stage.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the tile side, out_valid/out_ready on the result side.
interface win_out_at_if #(
  parameter int DW = 16,
  parameter int AW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            first_tile;
  logic            last_tile;
  logic [4*DW-1:0] m_row1;
  logic [4*DW-1:0] m_row2;
  logic [4*DW-1:0] m_row3;
  logic [4*DW-1:0] m_row4;
  logic [2*AW-1:0] y_row1;
  logic [2*AW-1:0] y_row2;
  logic            out_valid;
  logic            out_ready;
  logic            overflow;
  logic            end_signal;

  // Block side
  modport slave (
    input  in_valid, first_tile, last_tile, m_row1, m_row2, m_row3, m_row4, out_ready,
    output in_ready, y_row1, y_row2, out_valid, overflow, end_signal
  );

  // Producer / consumer side
  modport master (
    output in_valid, first_tile, last_tile, m_row1, m_row2, m_row3, m_row4, out_ready,
    input  in_ready, y_row1, y_row2, out_valid, overflow, end_signal
  );
endinterface

// File: rtl/win_at_row.sv
// Combinational 4->2 Winograd output combiner: s1 = a+b+c, s2 = b-c-d.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module win_at_row
  import win_out_at_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W+1:0] s1_o,
  output logic signed [W+1:0] s2_o
);

  logic signed [W+1:0] xa, xb, xc, xd;

  // One operand's contribution: dropped, added or subtracted.
  // Operands are sign-extended from W bits, so negation cannot overflow W+2.
  function automatic logic signed [W+1:0] term(input logic signed [W+1:0] v,
                                              input logic use_b,
                                              input logic neg_b);
    if (!use_b) return '0;
    return neg_b ? -v : v;
  endfunction

  assign xa = {{2{a_i[W-1]}}, a_i};
  assign xb = {{2{b_i[W-1]}}, b_i};
  assign xc = {{2{c_i[W-1]}}, c_i};
  assign xd = {{2{d_i[W-1]}}, d_i};

  // Three operands of magnitude <= 2^(W-1) always fit in W+2 signed bits.
  assign s1_o = term(xa, A_S1_USE[3], A_S1_NEG[3]) + term(xb, A_S1_USE[2], A_S1_NEG[2])
              + term(xc, A_S1_USE[1], A_S1_NEG[1]) + term(xd, A_S1_USE[0], A_S1_NEG[0]);
  assign s2_o = term(xa, A_S2_USE[3], A_S2_NEG[3]) + term(xb, A_S2_USE[2], A_S2_NEG[2])
              + term(xc, A_S2_USE[1], A_S2_NEG[1]) + term(xd, A_S2_USE[0], A_S2_NEG[0]);

endmodule

// File: rtl/win_out_at.sv
// Winograd F(2,3) output transform Y = At*M*A with cross-channel accumulation.
// Latency: accept at edge E, result presented after edge E+3, consumed at E+4 earliest.
// Backpressure: in_ready only in IDLE; OUT holds the result until out_ready.
module win_out_at
  import win_out_at_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input logic         clk,
  input logic         rst_n,
  win_out_at_if.slave bus
);

  state_t               state_q, state_d;
  logic                 in_ready_q;
  logic                 first_q, last_q;
  logic                 ovf_q, ovf_d;
  logic                 end_q, end_d;
  logic                 accept;
  logic signed [DW-1:0] m_q   [4][4];
  logic signed [DW+1:0] t_w   [2][4];
  logic signed [DW+1:0] t_q   [2][4];
  logic signed [DW+3:0] y_w   [2][2];
  logic signed [DW+3:0] y_q   [2][2];
  logic signed [AW-1:0] acc_q [2][2];
  logic signed [AW-1:0] acc_n [2][2];
  logic [3:0]           ovf_e;
  logic [2*AW-1:0]      y_row1_q, y_row1_d;
  logic [2*AW-1:0]      y_row2_q, y_row2_d;

  assign accept = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;

  // First pass: T = At*M, one combiner per column of M
  for (genvar gj = 0; gj < 4; gj++) begin : g_stg1
    win_at_row #(.W(DW)) u_col (
      .a_i  (m_q[0][gj]),
      .b_i  (m_q[1][gj]),
      .c_i  (m_q[2][gj]),
      .d_i  (m_q[3][gj]),
      .s1_o (t_w[0][gj]),
      .s2_o (t_w[1][gj])
    );
  end

  // Second pass: Y = T*A, one combiner per row of T
  for (genvar gi = 0; gi < 2; gi++) begin : g_stg2
    win_at_row #(.W(DW + 2)) u_row (
      .a_i  (t_q[gi][0]),
      .b_i  (t_q[gi][1]),
      .c_i  (t_q[gi][2]),
      .d_i  (t_q[gi][3]),
      .s1_o (y_w[gi][0]),
      .s2_o (y_w[gi][1])
    );
  end

  // Accumulate adds; a first tile starts from zero so it can never flag overflow
  for (genvar gi = 0; gi < 2; gi++) begin : g_acc_r
    for (genvar gj = 0; gj < 2; gj++) begin : g_acc_c
      logic signed [AW-1:0] base;
      logic signed [AW-1:0] addend;
      assign base   = first_q ? '0 : acc_q[gi][gj];
      assign addend = AW'(y_q[gi][gj]);
      assign acc_n[gi][gj] = base + addend;
      assign ovf_e[gi*2 + gj] = (base[AW-1] == addend[AW-1]) &&
                                (acc_n[gi][gj][AW-1] != base[AW-1]);
    end
  end

  // Next-state logic: FSM sequencing, sticky overflow, result capture, end pulse
  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    y_row1_d = y_row1_q;
    y_row2_d = y_row2_q;
    end_d    = UnFinish;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_STG1;
      ST_STG1: state_d = ST_STG2;
      ST_STG2: state_d = ST_ACC;
      ST_ACC: begin
        ovf_d = (first_q ? 1'b0 : ovf_q) | (|ovf_e);
        if (last_q) begin
          y_row1_d = {acc_n[0][0], acc_n[0][1]};
          y_row2_d = {acc_n[1][0], acc_n[1][1]};
          state_d  = ST_OUT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          end_d   = Finish;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial tile and the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      end_q      <= UnFinish;
      y_row1_q   <= '0;
      y_row2_q   <= '0;
      m_q        <= '{default: '0};
      t_q        <= '{default: '0};
      y_q        <= '{default: '0};
      acc_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
      ovf_q      <= ovf_d;
      end_q      <= end_d;
      y_row1_q   <= y_row1_d;
      y_row2_q   <= y_row2_d;
      if (accept) begin
        first_q <= bus.first_tile;
        last_q  <= bus.last_tile;
        for (int j = 0; j < 4; j++) begin
          m_q[0][j] <= bus.m_row1[(3-j)*DW +: DW];
          m_q[1][j] <= bus.m_row2[(3-j)*DW +: DW];
          m_q[2][j] <= bus.m_row3[(3-j)*DW +: DW];
          m_q[3][j] <= bus.m_row4[(3-j)*DW +: DW];
        end
      end
      if (state_q == ST_STG1) t_q <= t_w;
      if (state_q == ST_STG2) y_q <= y_w;
      if (state_q == ST_ACC)  acc_q <= acc_n;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.y_row1     = y_row1_q;
  assign bus.y_row2     = y_row2_q;
  assign bus.overflow   = ovf_q;
  assign bus.end_signal = end_q;

endmodule
